mem_arbiter: RTL and testbench

//   Shares the single-port unified memory (one transaction per cycle, shared funct3, 1-cycle read

---
 rtl/mem_arbiter.sv | 118 +++++++++++
 tb/tb_mem_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates the single-port unified memory between instruction fetch (IF) and load/store (LS).
// One grant per cycle; the response comes back on the matching channel exactly one cycle later.
module mem_arbiter #(
  parameter int unsigned MAX_LS_STREAK = 4,
  parameter logic [2:0]  FETCH_FUNCT3  = 3'b010
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [31:0] if_addr,
  output logic        if_rsp_valid,
  output logic [31:0] if_rsp_data,
  input  logic        ls_req_valid,
  output logic        ls_req_ready,
  input  logic        ls_req_write,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  input  logic [2:0]  ls_funct3,
  output logic        ls_rsp_valid,
  output logic [31:0] ls_rsp_data,
  output logic        mem_write_mem,
  output logic [2:0]  mem_funct3,
  output logic [31:0] mem_write_address,
  output logic [31:0] mem_write_data,
  output logic [31:0] mem_read_address,
  input  logic [31:0] mem_read_data
);

  localparam logic [1:0] LAST_IDLE  = 2'd0;
  localparam logic [1:0] LAST_FETCH = 2'd1;
  localparam logic [1:0] LAST_LOAD  = 2'd2;
  localparam logic [1:0] LAST_STORE = 2'd3;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_LS_STREAK);

  logic [1:0] last, last_next;
  logic [3:0] streak, streak_next;
  logic       grant_if, grant_ls;

  // LS has priority on contention until it has starved a waiting IF for STREAK_MAX grants.
  always_comb begin
    grant_if = 1'b0;
    grant_ls = 1'b0;
    if (rst_n) begin
      if (if_req_valid && ls_req_valid) begin
        if (streak == STREAK_MAX) grant_if = 1'b1;
        else                      grant_ls = 1'b1;
      end else begin
        grant_if = if_req_valid;
        grant_ls = ls_req_valid;
      end
    end
  end

  assign if_req_ready = grant_if;
  assign ls_req_ready = grant_ls;

  always_comb begin
    last_next   = LAST_IDLE;
    streak_next = streak;
    if (grant_if)      last_next = LAST_FETCH;
    else if (grant_ls) last_next = ls_req_write ? LAST_STORE : LAST_LOAD;

    if (!if_req_valid || grant_if)           streak_next = 4'd0;
    else if (grant_ls && streak != STREAK_MAX) streak_next = streak + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last   <= LAST_IDLE;
      streak <= 4'd0;
    end else begin
      last   <= last_next;
      streak <= streak_next;
    end
  end

  always_comb begin
    mem_write_mem     = 1'b0;
    mem_funct3        = FETCH_FUNCT3;
    mem_write_address = 32'd0;
    mem_write_data    = 32'd0;
    mem_read_address  = 32'd0;
    if (grant_if) begin
      mem_read_address = if_addr;
    end else if (grant_ls) begin
      mem_funct3       = ls_funct3;
      mem_read_address = ls_addr;
      if (ls_req_write) begin
        mem_write_mem     = 1'b1;
        mem_write_address = ls_addr;
        mem_write_data    = ls_wdata;
      end
    end
  end

  // Memory read data is routed by what was granted last cycle; stores only get an ack.
  always_comb begin
    if_rsp_valid = 1'b0;
    if_rsp_data  = 32'd0;
    ls_rsp_valid = 1'b0;
    ls_rsp_data  = 32'd0;
    case (last)
      LAST_FETCH: begin
        if_rsp_valid = 1'b1;
        if_rsp_data  = mem_read_data;
      end
      LAST_LOAD: begin
        ls_rsp_valid = 1'b1;
        ls_rsp_data  = mem_read_data;
      end
      LAST_STORE: ls_rsp_valid = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a byte-level memory model answers the DUT, and a transaction-level
// reference model predicts grants, memory drive and responses every cycle.
module tb_mem_arbiter;

  localparam int         MAX_STREAK = 4;
  localparam logic [2:0] FETCH_F3   = 3'b010;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req_valid = 1'b0;
  logic        if_req_ready;
  logic [31:0] if_addr = 32'd0;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_data;
  logic        ls_req_valid = 1'b0;
  logic        ls_req_ready;
  logic        ls_req_write = 1'b0;
  logic [31:0] ls_addr = 32'd0;
  logic [31:0] ls_wdata = 32'd0;
  logic [2:0]  ls_funct3 = 3'b010;
  logic        ls_rsp_valid;
  logic [31:0] ls_rsp_data;
  logic        mem_write_mem;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_write_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_address;
  logic [31:0] mem_read_data = 32'd0;

  always #5 clk = ~clk;

  mem_arbiter #(.MAX_LS_STREAK(MAX_STREAK), .FETCH_FUNCT3(FETCH_F3)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_write(ls_req_write),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_funct3(ls_funct3),
    .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
    .mem_write_mem(mem_write_mem), .mem_funct3(mem_funct3),
    .mem_write_address(mem_write_address), .mem_write_data(mem_write_data),
    .mem_read_address(mem_read_address), .mem_read_data(mem_read_data)
  );

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Two independent byte stores: env_bytes backs the memory the DUT talks to,
  // ref_bytes is what the reference model believes memory holds.
  logic [7:0] env_bytes [int unsigned];
  logic [7:0] ref_bytes [int unsigned];

  function automatic bit in_range(input logic [31:0] a);
    return (a < 32'h0000_1000) || (a >= 32'hFFFF_FFFC);
  endfunction

  function automatic logic [7:0] get_byte(input bit use_ref, input logic [31:0] a);
    if (!in_range(a)) return 8'h00;
    if (use_ref) begin
      if (ref_bytes.exists(a)) return ref_bytes[a];
    end else begin
      if (env_bytes.exists(a)) return env_bytes[a];
    end
    return (a < 32'h0000_1000) ? (a[7:0] ^ 8'h5A) : 8'h00;
  endfunction

  function automatic void put_byte(input bit use_ref, input logic [31:0] a, input logic [7:0] d);
    if (!in_range(a)) return;
    if (use_ref) ref_bytes[a] = d;
    else         env_bytes[a] = d;
  endfunction

  function automatic logic [31:0] mem_read(input bit use_ref, input logic [31:0] a, input logic [2:0] f3);
    logic [7:0] b0, b1, b2, b3;
    b0 = get_byte(use_ref, a);
    b1 = get_byte(use_ref, a + 32'd1);
    b2 = get_byte(use_ref, a + 32'd2);
    b3 = get_byte(use_ref, a + 32'd3);
    case (f3)
      3'b000:  return {{24{b0[7]}}, b0};
      3'b001:  return {{16{b1[7]}}, b1, b0};
      3'b100:  return {24'd0, b0};
      3'b101:  return {16'd0, b1, b0};
      default: return {b3, b2, b1, b0};
    endcase
  endfunction

  function automatic void mem_write(input bit use_ref, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    int n;
    n = (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : 4;
    for (int i = 0; i < n; i++) put_byte(use_ref, a + 32'(i), d[8*i +: 8]);
  endfunction

  always @(posedge clk) begin
    if (mem_write_mem) mem_write(1'b0, mem_write_address, mem_write_data, mem_funct3);
    mem_read_data <= mem_read(1'b0, mem_read_address, mem_funct3);
  end

  // Reference model state: which channel owes a response next cycle and with what data.
  int          pend_kind = 0;
  logic [31:0] pend_data = 32'd0;
  int          streak_m = 0;
  bit          started = 1'b0;
  bit          exp_if, exp_ls;
  logic [31:0] if_rsp_log [$];
  logic [31:0] ls_rsp_log [$];

  always @(negedge clk) begin
    exp_if = 1'b0;
    exp_ls = 1'b0;
    if (rst_n) begin
      if (if_req_valid && ls_req_valid) begin
        if (streak_m >= MAX_STREAK) exp_if = 1'b1;
        else                        exp_ls = 1'b1;
      end else begin
        exp_if = if_req_valid;
        exp_ls = ls_req_valid;
      end
    end

    if (started) begin
      checkOutput("if_rsp_valid", 32'(if_rsp_valid), 32'(pend_kind == 1));
      checkOutput("if_rsp_data", if_rsp_data, (pend_kind == 1) ? pend_data : 32'd0);
      checkOutput("ls_rsp_valid", 32'(ls_rsp_valid), 32'(pend_kind == 2));
      checkOutput("ls_rsp_data", ls_rsp_data, (pend_kind == 2) ? pend_data : 32'd0);
      if (if_rsp_valid) if_rsp_log.push_back(if_rsp_data);
      if (ls_rsp_valid) ls_rsp_log.push_back(ls_rsp_data);

      checkOutput("if_req_ready", 32'(if_req_ready), 32'(exp_if));
      checkOutput("ls_req_ready", 32'(ls_req_ready), 32'(exp_ls));
      checkOutput("mem_write_mem", 32'(mem_write_mem), 32'(exp_ls && ls_req_write));
      if (exp_if) begin
        checkOutput("fetch_read_address", mem_read_address, if_addr);
        checkOutput("fetch_funct3", 32'(mem_funct3), 32'(FETCH_F3));
      end else if (exp_ls) begin
        checkOutput("ls_read_address", mem_read_address, ls_addr);
        checkOutput("ls_funct3", 32'(mem_funct3), 32'(ls_funct3));
        if (ls_req_write) begin
          checkOutput("store_write_address", mem_write_address, ls_addr);
          checkOutput("store_write_data", mem_write_data, ls_wdata);
        end
      end else begin
        checkOutput("idle_read_address", mem_read_address, 32'd0);
        checkOutput("idle_write_address", mem_write_address, 32'd0);
        checkOutput("idle_write_data", mem_write_data, 32'd0);
        checkOutput("idle_funct3", 32'(mem_funct3), 32'(FETCH_F3));
      end
    end

    if (!rst_n) begin
      pend_kind = 0;
      pend_data = 32'd0;
      streak_m  = 0;
      started   = 1'b1;
    end else begin
      pend_kind = 0;
      pend_data = 32'd0;
      if (exp_if) begin
        pend_kind = 1;
        pend_data = mem_read(1'b1, if_addr, FETCH_F3);
      end else if (exp_ls) begin
        pend_kind = 2;
        if (ls_req_write) mem_write(1'b1, ls_addr, ls_wdata, ls_funct3);
        else              pend_data = mem_read(1'b1, ls_addr, ls_funct3);
      end
      if (!if_req_valid || exp_if) streak_m = 0;
      else if (exp_ls && streak_m < MAX_STREAK) streak_m++;
    end
  end

  // Drives one cycle of requests (from just after a posedge) and reports the grants seen.
  task automatic applyStimulus(input bit iv, input logic [31:0] ia,
                               input bit lv, input bit lw, input logic [31:0] la,
                               input logic [31:0] ld, input logic [2:0] lf,
                               output bit gi, output bit gl);
    if_req_valid = iv;
    if_addr      = ia;
    ls_req_valid = lv;
    ls_req_write = lw;
    ls_addr      = la;
    ls_wdata     = ld;
    ls_funct3    = lf;
    @(negedge clk);
    gi = if_req_ready;
    gl = ls_req_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(output bit gi, output bit gl);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 3'b010, gi, gl);
  endtask

  initial begin
    bit gi, gl;
    logic [9:0]  pat1;
    logic [7:0]  pat2;
    logic [31:0] ia, la, ld;
    bit          iv, lv, lw;
    logic [2:0]  lf;

    // Reset held with both requesters asking (LS asking for a store).
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'h4, 1'b1, 1'b1, 32'h10, 32'h1234, 3'b010, gi, gl);
      checkOutput("reset_if_ready", 32'(gi), 32'd0);
      checkOutput("reset_ls_ready", 32'(gl), 32'd0);
    end
    rst_n = 1'b1;
    idle(gi, gl);
    idle(gi, gl);
    checkOutput("post_reset_rsp_count", 32'(if_rsp_log.size() + ls_rsp_log.size()), 32'd0);

    // Back-to-back fetches from preloaded memory.
    if_rsp_log.delete();
    applyStimulus(1'b1, 32'h4, 1'b0, 1'b0, 32'd0, 32'd0, 3'b010, gi, gl);
    checkOutput("fetch_grant_same_cycle", 32'(gi), 32'd1);
    applyStimulus(1'b1, 32'h8, 1'b0, 1'b0, 32'd0, 32'd0, 3'b010, gi, gl);
    applyStimulus(1'b1, 32'hC, 1'b0, 1'b0, 32'd0, 32'd0, 3'b010, gi, gl);
    idle(gi, gl);
    checkOutput("fetch_count", 32'(if_rsp_log.size()), 32'd3);
    if (if_rsp_log.size() == 3) begin
      checkOutput("fetch_0x4", if_rsp_log[0], 32'h5D5C_5F5E);
      checkOutput("fetch_0x8", if_rsp_log[1], 32'h5150_5352);
      checkOutput("fetch_0xC", if_rsp_log[2], 32'h5554_5756);
    end

    // Store then byte loads on the following cycles.
    ls_rsp_log.delete();
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 3'b010, gi, gl);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'h101, 32'd0, 3'b100, gi, gl);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'h103, 32'd0, 3'b000, gi, gl);
    // MMIO register round trip, then an unmapped address.
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'h8040_2010, 3'b010, gi, gl);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'd0, 3'b010, gi, gl);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'h2000_0000, 32'd0, 3'b010, gi, gl);
    idle(gi, gl);
    checkOutput("ls_count", 32'(ls_rsp_log.size()), 32'd6);
    if (ls_rsp_log.size() == 6) begin
      checkOutput("sw_ack", ls_rsp_log[0], 32'd0);
      checkOutput("lbu_0x101", ls_rsp_log[1], 32'h0000_00BE);
      checkOutput("lb_0x103", ls_rsp_log[2], 32'hFFFF_FFDE);
      checkOutput("mmio_ack", ls_rsp_log[3], 32'd0);
      checkOutput("mmio_lw", ls_rsp_log[4], 32'h8040_2010);
      checkOutput("unmapped_lw", ls_rsp_log[5], 32'd0);
    end

    // Continuous contention: expect LS x4 then IF, repeating.
    ia = 32'h20;
    la = 32'h40;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, ia, 1'b1, 1'b0, la, 32'd0, 3'b010, gi, gl);
      pat1[i] = gi;
      if (gi) ia += 32'd4;
      if (gl) la += 32'd4;
    end
    checkOutput("contention_pattern", 32'(pat1), 32'h210);

    // A single cycle without IF request clears the streak.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(i != 2, ia, 1'b1, 1'b0, la, 32'd0, 3'b010, gi, gl);
      pat2[i] = gi;
      if (gi) ia += 32'd4;
      if (gl) la += 32'd4;
    end
    checkOutput("streak_clear_pattern", 32'(pat2), 32'h80);
    idle(gi, gl);

    // Reset asserted while a load is requested: no grant and no response.
    ls_rsp_log.delete();
    rst_n = 1'b0;
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'h100, 32'd0, 3'b010, gi, gl);
    checkOutput("reset_mid_load_ready", 32'(gl), 32'd0);
    rst_n = 1'b1;
    idle(gi, gl);
    idle(gi, gl);
    checkOutput("reset_mid_load_rsp", 32'(ls_rsp_log.size()), 32'd0);

    // Randomized traffic with occasional resets.
    iv = 1'b0; lv = 1'b0; lw = 1'b0; lf = 3'b010;
    ia = 32'd0; la = 32'd0; ld = 32'd0;
    for (int c = 0; c < 500; c++) begin
      rst_n = ($urandom_range(0, 39) != 0);
      applyStimulus(iv, ia, lv, lw, la, ld, lf, gi, gl);
      if (gi || !iv) begin
        iv = ($urandom_range(0, 3) != 0);
        ia = 32'($urandom_range(0, 255)) << 2;
      end
      if (gl || !lv) begin
        lv = ($urandom_range(0, 2) != 0);
        lw = ($urandom_range(0, 2) == 0);
        ld = $urandom;
        case ($urandom_range(0, 5))
          0:       la = 32'hFFFF_FFFC;
          1:       la = 32'h2000_0000 + 32'($urandom_range(0, 15));
          default: la = 32'($urandom_range(0, 32'h1FF));
        endcase
        if (lw) begin
          case ($urandom_range(0, 2))
            0:       lf = 3'b000;
            1:       lf = 3'b001;
            default: lf = 3'b010;
          endcase
        end else begin
          case ($urandom_range(0, 4))
            0:       lf = 3'b000;
            1:       lf = 3'b001;
            2:       lf = 3'b100;
            3:       lf = 3'b101;
            default: lf = 3'b010;
          endcase
        end
      end
    end
    rst_n = 1'b1;
    idle(gi, gl);
    idle(gi, gl);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
